// File: rtl/tim_apb_master.sv
// -----------------------------------------------------------------------------
// tim_apb_master
//   APB4 requester for the timer block. Accepts one command at a time on a
//   valid/ready channel, runs it as a SETUP + ACCESS transfer on the tim_* bus,
//   and returns read data / error status on a valid/ready response channel.
//   Misaligned addresses (addr[1:0] != 0) never reach the bus and complete
//   with an error.
//
// Optional feature (compile-time macro TIM_APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees TIMEOUT_CYC cycles with
//   tim_pready low is abandoned and answered with slverr = 1, timeout = 1.
//   When undefined, ACCESS waits indefinitely and rsp_timeout is tied low.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/slverr/timeout   response payload (held stable while valid)
//   tim_psel/penable/pwrite/paddr/pwdata/pstrb   APB request outputs
//   tim_prdata/pready/pslverr                    APB completion inputs
// -----------------------------------------------------------------------------
module tim_apb_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_W-1:0]     tim_paddr,
  output logic [DATA_W-1:0]     tim_pwdata,
  output logic [DATA_W/8-1:0]   tim_pstrb,
  input  logic [DATA_W-1:0]     tim_prdata,
  input  logic                  tim_pready,
  input  logic                  tim_pslverr
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_ERR    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Elaboration-time guard on the parameter set this block is built for.
  if (ADDR_W < 2 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255)
  begin : g_param_check
    $error("tim_apb_master: unsupported ADDR_W/DATA_W/TIMEOUT_CYC");
  end

  logic [2:0]        state_q,  state_d;
  logic              write_q,  write_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [STRB_W-1:0] strb_q,   strb_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              slverr_q, slverr_d;

`ifdef TIM_APB_TIMEOUT_EN
  // The counter holds the number of stalled ACCESS cycles already seen; a
  // stalled cycle while it equals TIMEOUT_CYC-1 is the one that makes it
  // reach the limit, so that cycle aborts (unless pready arrives, which wins).
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q,     cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Bus and handshake controls are pure decodes of the state register, so
  // they change only on clock edges and a reset drops psel/penable at once.
  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign tim_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign tim_penable = (state_q == S_ACCESS);
  assign tim_pwrite  = write_q;
  assign tim_paddr   = addr_q;
  assign tim_pwdata  = wdata_q;
  assign tim_pstrb   = strb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
`ifdef TIM_APB_TIMEOUT_EN
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable assigned here first gets a hold-value default, so
    // no path through the case statement can leave one unassigned and infer
    // a latch.
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
`ifdef TIM_APB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          // Reads present all-zero data and strobes on the bus.
          wdata_d = cmd_write ? cmd_wdata : '0;
          strb_d  = cmd_write ? cmd_strb  : '0;
          state_d = (cmd_addr[1:0] == 2'b00) ? S_SETUP : S_ERR;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef TIM_APB_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
      end

      S_ACCESS: begin
        if (tim_pready) begin
          rdata_d  = write_q ? '0 : tim_prdata;
          slverr_d = tim_pslverr;
          state_d  = S_RESP;
`ifdef TIM_APB_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end

      S_ERR: begin
        rdata_d  = '0;
        slverr_d = 1'b1;
        state_d  = S_RESP;
`ifdef TIM_APB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
      end

      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
`ifdef TIM_APB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
`ifdef TIM_APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_tim_apb_master.sv
// -----------------------------------------------------------------------------
// tb_tim_apb_master
//   Scoreboard bench for tim_apb_master. Commands are issued with the
//   expected response pushed into exp_q; an independent monitor pops and
//   compares at every response handshake. A behavioural APB slave with a
//   word memory serves the bus with per-command wait states and errors, and
//   checks the bus phases and held request fields.
// -----------------------------------------------------------------------------
module tb_tim_apb_master;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;
  localparam int TIMEOUT_CYC = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [STRB_W-1:0] cmd_strb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic              tim_psel, tim_penable, tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata;
  logic [STRB_W-1:0] tim_pstrb;
  logic [DATA_W-1:0] tim_prdata = '0;
  logic              tim_pready = 1'b0;
  logic              tim_pslverr = 1'b0;

  tim_apb_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic slverr; logic timeout; } rsp_t;
  typedef struct { logic write; logic [11:0] addr; logic [31:0] wdata; logic [3:0] strb; } apb_t;
  typedef struct { int waits; logic err; } slv_t;

  rsp_t exp_q[$];
  apb_t apb_q[$];
  slv_t slv_q[$];

  logic [31:0] ref_mem [1024];
  logic [31:0] slv_mem [1024];

  int tests = 0;
  int fails = 0;

  int acc_cyc, last_setup_cyc, last_access_cyc, last_rsp_cyc;
  int setup_count = 0;
  int max_rsp_len = 0;
  int rdy_pct = 100;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[b*8 +: 8] = d[b*8 +: 8];
    return old;
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int waits, input logic err,
                       input bit expect_rsp, input bit abort_by_timeout);
    rsp_t r;
    int   n;
    logic [9:0] idx;
    idx = addr[11:2];
    if (addr[1:0] == 2'b00) begin
      apb_q.push_back('{write: wr, addr: addr, wdata: (wr ? wdata : 32'h0),
                        strb: (wr ? strb : 4'h0)});
      slv_q.push_back('{waits: waits, err: err});
    end
    if (addr[1:0] != 2'b00)  r = '{rdata: 32'h0, slverr: 1'b1, timeout: 1'b0};
    else if (abort_by_timeout) r = '{rdata: 32'h0, slverr: 1'b1, timeout: 1'b1};
    else if (wr) begin
      r = '{rdata: 32'h0, slverr: err, timeout: 1'b0};
      if (!err) ref_mem[idx] = merge(ref_mem[idx], wdata, strb);
    end else
      r = '{rdata: (err ? 32'h0 : ref_mem[idx]), slverr: err, timeout: 1'b0};
    if (expect_rsp) exp_q.push_back(r);

    @(negedge sys_clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_bound", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 500) check("drain_bound", 64'd0, 64'd1);
  endtask

  // Response-ready driver: changes just after the clock edge so the monitor
  // sees a settled value on the falling edge.
  always @(posedge sys_clk) begin
    #1;
    if (stall_cnt > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) stall_cnt--;
    end else
      rsp_ready = ($urandom_range(99) < rdy_pct);
  end

  // ---------------------------------------------------------- APB slave model
  apb_t cur_a;
  slv_t cur_s;
  int   wcnt = 0;
  logic prev_psel = 1'b0, prev_penable = 1'b0;

  always @(negedge sys_clk) begin
    // Outside the completing ACCESS cycle the slave inputs are noise.
    tim_pready  = 1'($urandom_range(1));
    tim_pslverr = 1'($urandom_range(1));
    tim_prdata  = $urandom;
    if (tim_penable && !tim_psel) check("penable_without_psel", 64'd1, 64'd0);
    if (tim_psel && !tim_penable) begin
      check("psel_gap_before_setup", 64'(prev_psel), 64'd0);
      setup_count++;
      last_setup_cyc = cyc;
      if (apb_q.size() == 0 || slv_q.size() == 0)
        check("unexpected_setup", 64'd1, 64'd0);
      else begin
        cur_a = apb_q.pop_front();
        cur_s = slv_q.pop_front();
        wcnt  = 0;
        check("setup_fields", {tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb},
              {cur_a.write, cur_a.addr, cur_a.wdata, cur_a.strb});
      end
    end else if (tim_psel && tim_penable) begin
      check("access_follows_setup", 64'(prev_psel), 64'd1);
      check("access_fields_held", {tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb},
            {cur_a.write, cur_a.addr, cur_a.wdata, cur_a.strb});
      if (!prev_penable) last_access_cyc = cyc;
      if (wcnt == cur_s.waits) begin
        tim_pready  = 1'b1;
        tim_pslverr = cur_s.err;
        if (tim_pwrite && !cur_s.err)
          slv_mem[tim_paddr[11:2]] = merge(slv_mem[tim_paddr[11:2]], tim_pwdata, tim_pstrb);
        tim_prdata = (!tim_pwrite && !cur_s.err) ? slv_mem[tim_paddr[11:2]] : 32'h0;
      end else begin
        tim_pready = 1'b0;
        wcnt++;
      end
    end
    prev_psel    = tim_psel;
    prev_penable = tim_penable;
  end

  // -------------------------------------------------------- response monitor
  logic        held = 1'b0;
  logic [33:0] held_val;
  logic        prev_rsp = 1'b0;
  int          rsp_len = 0;
  rsp_t        e;

  always @(negedge sys_clk) begin
    if (rsp_valid && !prev_rsp) last_rsp_cyc = cyc;
    if (rsp_valid) begin
      rsp_len++;
      check("rsp_cmd_ready_low", 64'(cmd_ready), 64'd0);
      check("rsp_no_apb", 64'(tim_psel), 64'd0);
      if (held) check("rsp_fields_stable", {rsp_rdata, rsp_slverr, rsp_timeout}, held_val);
      held     = 1'b1;
      held_val = {rsp_rdata, rsp_slverr, rsp_timeout};
      if (rsp_ready) begin
        held = 1'b0;
        if (rsp_len > max_rsp_len) max_rsp_len = rsp_len;
        rsp_len = 0;
        if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_slverr", rsp_slverr, e.slverr);
          check("rsp_timeout", rsp_timeout, e.timeout);
        end
      end
    end else begin
      held    = 1'b0;
      rsp_len = 0;
    end
    prev_rsp = rsp_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation bound expired, got %0d tests %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------- main
  initial begin
    int n, setups_before;
    logic        wr, err;
    logic [11:0] addr;

    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 32'hA5A5_0000 ^ i;
      slv_mem[i] = 32'hA5A5_0000 ^ i;
    end
    ref_mem[1] = 32'h1234_5678;
    slv_mem[1] = 32'h1234_5678;

    repeat (3) @(negedge sys_clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_apb_ctrl", {tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb}, 64'd0);
    check("reset_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, 64'd0);
    sys_rst = 1'b0;

    // Zero-wait write: SETUP at +1, first ACCESS at +2, response at +3.
    rdy_pct = 100;
    issue(1'b1, 12'h000, 32'h0000_0101, 4'hF, 0, 1'b0, 1'b1, 1'b0);
    wait_done();
    check("wr_setup_latency", 64'(last_setup_cyc - acc_cyc), 64'd1);
    check("wr_access_latency", 64'(last_access_cyc - acc_cyc), 64'd2);
    check("wr_rsp_latency", 64'(last_rsp_cyc - acc_cyc), 64'd3);

    // Read with three stalled ACCESS cycles.
    issue(1'b0, 12'h004, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 1'b1, 1'b0);
    wait_done();
    check("rd_wait_rsp_latency", 64'(last_rsp_cyc - last_access_cyc), 64'd4);

    // Slave error on a write at the top word, then a misaligned read.
    issue(1'b1, 12'hFFC, 32'hCAFE_F00D, 4'hF, 1, 1'b1, 1'b1, 1'b0);
    wait_done();
    setups_before = setup_count;
    issue(1'b0, 12'h002, 32'h0, 4'h0, 0, 1'b0, 1'b1, 1'b0);
    wait_done();
    check("misaligned_no_psel", 64'(setup_count - setups_before), 64'd0);
    check("misaligned_rsp_latency", 64'(last_rsp_cyc - acc_cyc), 64'd2);

    // Response held off for five cycles while the next command is pending.
    max_rsp_len = 0;
    stall_cnt   = 5;
    issue(1'b1, 12'h020, 32'h0BAD_F00D, 4'h5, 0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b0, 1'b1, 1'b0);
    wait_done();
    check("rsp_hold_length", 64'(max_rsp_len >= 6), 64'd1);

    // Reset while ACCESS is stalled: bus drops, no response, idle afterwards.
    issue(1'b0, 12'h008, 32'h0, 4'h0, 1000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(tim_psel && tim_penable) && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("reach_access_before_reset", 64'(tim_psel && tim_penable), 64'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("reset_drops_bus", {tim_psel, tim_penable}, 64'd0);
    check("reset_no_rsp", 64'(rsp_valid), 64'd0);
    check("reset_cmd_ready_high", 64'(cmd_ready), 64'd1);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

`ifdef TIM_APB_TIMEOUT_EN
    // Never-ready slave: abort after TIMEOUT_CYC stalled ACCESS cycles.
    issue(1'b0, 12'h00C, 32'h0, 4'h0, 1000, 1'b0, 1'b1, 1'b1);
    wait_done();
    check("timeout_abort_latency", 64'(last_rsp_cyc - last_access_cyc), 64'(TIMEOUT_CYC));
    // pready on the limit cycle completes normally.
    issue(1'b0, 12'h010, 32'h0, 4'h0, TIMEOUT_CYC - 1, 1'b0, 1'b1, 1'b0);
    wait_done();
    check("timeout_edge_latency", 64'(last_rsp_cyc - last_access_cyc), 64'(TIMEOUT_CYC));
`endif

    // Randomised traffic, back-to-back issue, random response back-pressure.
    rdy_pct = 70;
    for (int t = 0; t < 200; t++) begin
      wr   = 1'($urandom_range(1));
      addr = 12'($urandom_range(4095));
      if ($urandom_range(9) != 0) addr[1:0] = 2'b00;
      err  = ($urandom_range(6) == 0);
      issue(wr, addr, $urandom, 4'($urandom_range(15)), $urandom_range(5), err, 1'b1, 1'b0);
    end
    wait_done();
    check("queues_drained", 64'(exp_q.size() + apb_q.size() + slv_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tim_apb_master.md
Name: tim_apb_master

Overview:
- Upstream APB requester for the timer: converts a simple valid/ready command channel (CPU shim or test sequencer) into APB4 SETUP/ACCESS transfers on the tim_* bus.
- Waits for tim_pready, then returns read data and error status on a valid/ready response channel.
- One outstanding transfer at a time; enforces APB timing so the timer slave only ever sees legal phases.

Parameters:
- ADDR_W, 12, width of cmd_addr/tim_paddr
- DATA_W, 32, width of write/read data
- TIMEOUT_CYC, 16, ACCESS-phase cycle limit before abort (used only with TIM_APB_TIMEOUT_EN)

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_slverr  out  1  error status for the transfer
- rsp_timeout  out  1  transfer aborted by timeout
- tim_psel, tim_penable, tim_pwrite  out  1 each  APB control
- tim_paddr  out  ADDR_W  APB address
- tim_pwdata  out  DATA_W  APB write data
- tim_pstrb  out  DATA_W/8  APB strobes
- tim_prdata  in  DATA_W  APB read data
- tim_pready  in  1  APB ready
- tim_pslverr  in  1  APB error

Behaviour:
- Reset (sys_rst high at a clock edge): state = IDLE; all outputs 0 except cmd_ready = 1.
- Reset mid-transfer: psel/penable drop at that edge, the pending response is discarded, and no rsp_valid is issued.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid, register write/addr/wdata/strb. Aligned address (addr[1:0] == 0) -> SETUP. Misaligned address -> ERR.
  - SETUP: psel = 1, penable = 0, for exactly one cycle -> ACCESS.
  - ACCESS: psel = 1, penable = 1. Stay while tim_pready = 0. On tim_pready = 1:
    - capture rsp_rdata = tim_prdata for reads, 0 for writes;
    - capture rsp_slverr = tim_pslverr;
    - -> RESP.
  - ERR: no APB activity; rsp_slverr = 1, rsp_rdata = 0 -> RESP.
  - RESP: rsp_valid = 1, fields held stable; psel = 0, cmd_ready = 0. On rsp_ready -> IDLE.
- cmd_ready is 1 only in IDLE; commands presented in other states are not accepted.
- tim_paddr, tim_pwrite, tim_pwdata and tim_pstrb are registered at accept and held constant from SETUP through the final ACCESS cycle.
- Reads drive tim_pstrb = 0 and tim_pwdata = 0.
- psel is always low for at least one cycle between back-to-back transfers (RESP/IDLE).
- Latency with pready = 1 in the first ACCESS cycle:
  - accept edge = cycle 0; SETUP = cycle 1; ACCESS = cycle 2;
  - rsp_valid = 1 from cycle 3;
  - earliest next accept = cycle 4 when rsp_ready is held high.
- tim_pslverr is sampled only on the ACCESS cycle where tim_pready = 1.
- rsp_timeout = 0 on every normal or ERR completion.

Optional Feature:
- Macro TIM_APB_TIMEOUT_EN.
- Defined:
  - an 8-bit counter clears on entering ACCESS and increments on each ACCESS cycle with tim_pready = 0;
  - when it reaches TIMEOUT_CYC, drop psel/penable on the next edge and go to RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0;
  - a pready arriving in the same cycle as the limit wins and completes normally.
- Not defined: ACCESS waits indefinitely, rsp_timeout is tied to 0, and TIMEOUT_CYC is ignored.

Test Plan:
- Write addr 0x000, wdata 0x0000_0101, strb 0xF; slave pready = 1 immediately -> psel in cycle 1, penable in cycle 2, paddr = 0x000 and pwdata = 0x0000_0101 stable; rsp_valid in cycle 3 with slverr = 0, rdata = 0.
- Read addr 0x004, slave holds pready = 0 for 3 ACCESS cycles then returns prdata = 0x1234_5678 -> pstrb = 0 throughout, rsp_rdata = 0x1234_5678, rsp_valid 4 cycles after the first ACCESS cycle.
- Write addr 0xFFC with slave pslverr = 1 on the pready cycle -> rsp_slverr = 1, rsp_timeout = 0; a misaligned read at 0x002 -> no psel ever asserted, rsp_valid 2 cycles after accept, slverr = 1.
- Hold rsp_ready = 0 for 5 cycles after rsp_valid while cmd_valid is held high -> response fields stable, cmd_ready = 0, no APB activity; after the handshake, the next command is accepted with psel low for at least 1 cycle between transfers.
- sys_rst pulsed high during ACCESS (pready = 0) -> psel and penable are 0 on the next edge, rsp_valid never asserts, cmd_ready = 1 afterwards.
- With TIM_APB_TIMEOUT_EN and TIMEOUT_CYC = 16, pready held at 0 -> abort after 16 ACCESS cycles with rsp_slverr = 1, rsp_timeout = 1; repeat with pready = 1 on the 16th cycle -> normal completion, rsp_timeout = 0.
